// File: rtl/axi_slave_interface.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_interface
// Brief    : AXI4 responder that terminates single-outstanding INCR/FIXED
//            bursts onto a single-port, word-addressed memory with a
//            1-cycle synchronous read latency.
// Revision : 1.0 - initial release
// ============================================================================
module axi_slave_interface #(
    parameter int                            C_S_AXI_ADDR_WIDTH      = 32,
    parameter int                            C_S_AXI_DATA_WIDTH      = 32,
    parameter int                            C_S_AXI_THREAD_ID_WIDTH = 1,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_AXI_TARGET          = '0,
    parameter int                            C_MEM_ADDR_WIDTH        = 10
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    // write address
    input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [7:0]                           S_AXI_AWLEN,
    input  logic [2:0]                           S_AXI_AWSIZE,
    input  logic [1:0]                           S_AXI_AWBURST,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    // write data
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WLAST,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    // write response
    output logic [C_S_AXI_THREAD_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    // read address
    input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [7:0]                           S_AXI_ARLEN,
    input  logic [2:0]                           S_AXI_ARSIZE,
    input  logic [1:0]                           S_AXI_ARBURST,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    // read data
    output logic [C_S_AXI_THREAD_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RLAST,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    // memory side
    output logic [C_MEM_ADDR_WIDTH-1:0]          mem_addr,
    output logic                                 mem_we,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        mem_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]      mem_wstrb,
    output logic                                 mem_re,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        mem_rdata
);

    localparam int         c_STRB_WIDTH  = C_S_AXI_DATA_WIDTH / 8;
    localparam int         c_LOG_BYTES   = $clog2(c_STRB_WIDTH);
    localparam int         c_WIN_SHIFT   = C_MEM_ADDR_WIDTH + c_LOG_BYTES;
    localparam logic [2:0] c_FULL_SIZE   = 3'(c_LOG_BYTES);
    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t                               r_state;
    logic [C_S_AXI_THREAD_ID_WIDTH-1:0]   r_id;
    logic [1:0]                           r_burst;
    logic [C_MEM_ADDR_WIDTH-1:0]          r_addr;
    logic                                 r_err;
    logic [8:0]                           r_beats;     // write beats left, or read beats left to issue
    logic [8:0]                           r_deliver;   // read beats left to hand over on R
    logic                                 r_last_wr;   // last address grant went to the write channel
    logic                                 r_inflight;  // a memory read issued last cycle lands now
    logic [C_S_AXI_DATA_WIDTH-1:0]        r_fifo0;
    logic [C_S_AXI_DATA_WIDTH-1:0]        r_fifo1;
    logic [1:0]                           r_count;

    logic                                 w_aw_grant;
    logic                                 w_ar_grant;
    logic [C_S_AXI_ADDR_WIDTH-1:0]        w_ax_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0]        w_ax_off;
    logic [C_MEM_ADDR_WIDTH-1:0]          w_ax_word;
    logic [7:0]                           w_ax_len;
    logic [2:0]                           w_ax_size;
    logic [1:0]                           w_ax_burst;
    logic [C_S_AXI_THREAD_ID_WIDTH-1:0]   w_ax_id;
    logic                                 w_ax_err;
    logic                                 w_w_hs;
    logic                                 w_pop;
    logic [2:0]                           w_occ;
    logic                                 w_issue;
    logic [C_S_AXI_DATA_WIDTH-1:0]        w_push_data;
    logic [C_MEM_ADDR_WIDTH-1:0]          w_addr_next;

    // Round-robin arbitration: on a tie the channel not served last wins.
    assign w_aw_grant = (r_state == ST_IDLE) && S_AXI_AWVALID && (!S_AXI_ARVALID || !r_last_wr);
    assign w_ar_grant = (r_state == ST_IDLE) && S_AXI_ARVALID && (!S_AXI_AWVALID ||  r_last_wr);

    // Shared decode of whichever address channel is being granted.
    assign w_ax_addr  = w_aw_grant ? S_AXI_AWADDR  : S_AXI_ARADDR;
    assign w_ax_len   = w_aw_grant ? S_AXI_AWLEN   : S_AXI_ARLEN;
    assign w_ax_size  = w_aw_grant ? S_AXI_AWSIZE  : S_AXI_ARSIZE;
    assign w_ax_burst = w_aw_grant ? S_AXI_AWBURST : S_AXI_ARBURST;
    assign w_ax_id    = w_aw_grant ? S_AXI_AWID    : S_AXI_ARID;
    // Unsigned offset: addresses below the base wrap to huge values and fail the window test.
    assign w_ax_off   = w_ax_addr - C_S_AXI_TARGET;
    assign w_ax_word  = C_MEM_ADDR_WIDTH'(w_ax_off >> c_LOG_BYTES);
    assign w_ax_err   = ((w_ax_off >> c_WIN_SHIFT) != '0) || (w_ax_size != c_FULL_SIZE);

    // WRAP is treated as INCR; INCR wraps naturally at the window size.
    assign w_addr_next = (r_burst == c_BURST_FIXED) ? r_addr : r_addr + C_MEM_ADDR_WIDTH'(1);

    assign w_w_hs      = (r_state == ST_WDATA) && S_AXI_WVALID;
    assign w_pop       = (r_count != 2'd0) && S_AXI_RREADY;
    // Buffered + landing beats after this cycle's pop; a new read only fits while below 2.
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == ST_RDATA) && (r_beats != 9'd0) && (w_occ < 3'd2);
    assign w_push_data = r_err ? '0 : mem_rdata;

    assign S_AXI_AWREADY = w_aw_grant && !ARESET;
    assign S_AXI_ARREADY = w_ar_grant && !ARESET;
    assign S_AXI_WREADY  = (r_state == ST_WDATA);
    assign S_AXI_BVALID  = (r_state == ST_WRESP);
    assign S_AXI_BID     = r_id;
    assign S_AXI_BRESP   = r_err ? c_RESP_SLVERR : c_RESP_OKAY;
    assign S_AXI_RVALID  = (r_count != 2'd0);
    assign S_AXI_RDATA   = r_fifo0;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RRESP   = r_err ? c_RESP_SLVERR : c_RESP_OKAY;
    assign S_AXI_RLAST   = S_AXI_RVALID && (r_deliver == 9'd1);

    assign mem_addr  = r_addr;
    assign mem_we    = w_w_hs && !r_err;
    assign mem_wdata = S_AXI_WDATA;
    assign mem_wstrb = S_AXI_WSTRB;
    // Errored reads keep their beat pacing but never touch the memory.
    assign mem_re    = w_issue && !r_err;

    // Transaction FSM with burst bookkeeping and the 2-entry read return buffer.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= ST_IDLE;
            r_id       <= '0;
            r_burst    <= 2'b01;
            r_addr     <= '0;
            r_err      <= 1'b0;
            r_beats    <= 9'd0;
            r_deliver  <= 9'd0;
            r_last_wr  <= 1'b0;
            r_inflight <= 1'b0;
            r_fifo0    <= '0;
            r_fifo1    <= '0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_grant || w_ar_grant) begin
                        r_id      <= w_ax_id;
                        r_burst   <= w_ax_burst;
                        r_addr    <= w_ax_word;
                        r_err     <= w_ax_err;
                        r_beats   <= {1'b0, w_ax_len} + 9'd1;
                        r_deliver <= {1'b0, w_ax_len} + 9'd1;
                        r_last_wr <= w_aw_grant;
                        r_state   <= w_aw_grant ? ST_WDATA : ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_w_hs) begin
                        r_addr  <= w_addr_next;
                        r_beats <= r_beats - 9'd1;
                        // The beat counter ends the burst; WLAST only audits it.
                        if (r_beats == 9'd1) begin
                            if (!S_AXI_WLAST) begin
                                r_err <= 1'b1;
                            end
                            r_state <= ST_WRESP;
                        end else if (S_AXI_WLAST) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WRESP: begin
                    if (S_AXI_BREADY) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (w_issue) begin
                        r_addr  <= w_addr_next;
                        r_beats <= r_beats - 9'd1;
                    end
                    case ({r_inflight, w_pop})
                        2'b10: begin
                            if (r_count == 2'd0) begin
                                r_fifo0 <= w_push_data;
                            end else begin
                                r_fifo1 <= w_push_data;
                            end
                            r_count <= r_count + 2'd1;
                        end
                        2'b01: begin
                            r_fifo0 <= r_fifo1;
                            r_count <= r_count - 2'd1;
                        end
                        2'b11: begin
                            if (r_count == 2'd1) begin
                                r_fifo0 <= w_push_data;
                            end else begin
                                r_fifo0 <= r_fifo1;
                                r_fifo1 <= w_push_data;
                            end
                        end
                        default: begin
                        end
                    endcase
                    if (w_pop) begin
                        r_deliver <= r_deliver - 9'd1;
                        if (r_deliver == 9'd1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_interface
// Brief    : Directed self-checking bench for axi_slave_interface with a
//            1-cycle-latency memory model behind the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_interface;

    localparam int          c_AW  = 32;
    localparam int          c_DW  = 32;
    localparam int          c_IW  = 2;
    localparam int          c_MAW = 10;
    localparam logic [31:0] c_TGT = 32'h0000_4000;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [c_IW-1:0]   S_AXI_AWID = '0;
    logic [c_AW-1:0]   S_AXI_AWADDR = '0;
    logic [7:0]        S_AXI_AWLEN = '0;
    logic [2:0]        S_AXI_AWSIZE = 3'd2;
    logic [1:0]        S_AXI_AWBURST = 2'b01;
    logic              S_AXI_AWVALID = 1'b0;
    logic              S_AXI_AWREADY;
    logic [c_DW-1:0]   S_AXI_WDATA = '0;
    logic [c_DW/8-1:0] S_AXI_WSTRB = '0;
    logic              S_AXI_WLAST = 1'b0;
    logic              S_AXI_WVALID = 1'b0;
    logic              S_AXI_WREADY;
    logic [c_IW-1:0]   S_AXI_BID;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY = 1'b0;
    logic [c_IW-1:0]   S_AXI_ARID = '0;
    logic [c_AW-1:0]   S_AXI_ARADDR = '0;
    logic [7:0]        S_AXI_ARLEN = '0;
    logic [2:0]        S_AXI_ARSIZE = 3'd2;
    logic [1:0]        S_AXI_ARBURST = 2'b01;
    logic              S_AXI_ARVALID = 1'b0;
    logic              S_AXI_ARREADY;
    logic [c_IW-1:0]   S_AXI_RID;
    logic [c_DW-1:0]   S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RLAST;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY = 1'b0;
    logic [c_MAW-1:0]  mem_addr;
    logic              mem_we;
    logic [c_DW-1:0]   mem_wdata;
    logic [c_DW/8-1:0] mem_wstrb;
    logic              mem_re;
    logic [c_DW-1:0]   mem_rdata;

    axi_slave_interface #(
        .C_S_AXI_ADDR_WIDTH      (c_AW),
        .C_S_AXI_DATA_WIDTH      (c_DW),
        .C_S_AXI_THREAD_ID_WIDTH (c_IW),
        .C_S_AXI_TARGET          (c_TGT),
        .C_MEM_ADDR_WIDTH        (c_MAW)
    ) u_dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [c_DW-1:0]  mem [0:(1<<c_MAW)-1];
    logic [c_MAW-1:0] wlog_addr [$];
    logic [c_DW-1:0]  wlog_data [$];
    logic [c_DW-1:0]  rd_data [$];
    logic             rd_last [$];
    logic [1:0]       rd_resp [$];
    logic [c_IW-1:0]  rd_id   [$];
    int               rd_cyc  [$];
    int               outstanding = 0;
    int               max_out = 0;
    logic             overlap = 1'b0;

    // Memory model (1-cycle read latency), write log and read-pacing monitor.
    always @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < c_DW/8; b++) begin
                if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we && mem_re) overlap = 1'b1;
        if (ARESET) outstanding = 0;
        else outstanding = outstanding + int'(mem_re) - int'(S_AXI_RVALID && S_AXI_RREADY);
        if (outstanding > max_out) max_out = outstanding;
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [31:0] base, input int wlast_at, input logic [c_IW-1:0] id,
                            input logic [2:0] size, output logic [1:0] bresp, output logic [c_IW-1:0] bid);
        int n;
        S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWSIZE = size;
        S_AXI_AWBURST = burst; S_AXI_AWID = id; S_AXI_AWVALID = 1'b1;
        #1;
        n = 0;
        while (!S_AXI_AWREADY && n < 32) begin tick(); #1; n++; end
        if (!S_AXI_AWREADY) check_value("aw_timeout", 0, 1);
        tick();
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            S_AXI_WDATA = base + 32'(i); S_AXI_WSTRB = '1;
            S_AXI_WLAST = (i == wlast_at); S_AXI_WVALID = 1'b1;
            #1;
            n = 0;
            while (!S_AXI_WREADY && n < 32) begin tick(); #1; n++; end
            if (!S_AXI_WREADY) check_value("w_timeout", 0, 1);
            tick();
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_BREADY = 1'b1;
        #1;
        n = 0;
        while (!S_AXI_BVALID && n < 32) begin tick(); #1; n++; end
        if (!S_AXI_BVALID) check_value("b_timeout", 0, 1);
        bresp = S_AXI_BRESP; bid = S_AXI_BID;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [c_IW-1:0] id, input bit toggle, output int lat);
        int n, cyc, got;
        logic stalled;
        logic [c_DW-1:0] held;
        rd_data.delete(); rd_last.delete(); rd_resp.delete(); rd_id.delete(); rd_cyc.delete();
        S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARSIZE = 3'd2;
        S_AXI_ARBURST = burst; S_AXI_ARID = id; S_AXI_ARVALID = 1'b1;
        #1;
        n = 0;
        while (!S_AXI_ARREADY && n < 32) begin tick(); #1; n++; end
        if (!S_AXI_ARREADY) check_value("ar_timeout", 0, 1);
        tick();
        S_AXI_ARVALID = 1'b0;
        cyc = 0; got = 0; lat = -1; stalled = 1'b0; held = '0;
        while (got <= len && cyc < 200) begin
            S_AXI_RREADY = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (stalled) begin
                check_value("r_hold_valid", S_AXI_RVALID, 1);
                check_value("r_hold_data", S_AXI_RDATA, held);
            end
            stalled = 1'b0;
            if (S_AXI_RVALID) begin
                if (lat < 0) lat = cyc;
                if (S_AXI_RREADY) begin
                    rd_data.push_back(S_AXI_RDATA); rd_last.push_back(S_AXI_RLAST);
                    rd_resp.push_back(S_AXI_RRESP); rd_id.push_back(S_AXI_RID);
                    rd_cyc.push_back(cyc);
                    got++;
                end else begin
                    stalled = 1'b1; held = S_AXI_RDATA;
                end
            end
            tick();
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
        if (got <= len) check_value("r_timeout", 0, 1);
    endtask

    logic [1:0]      bresp;
    logic [c_IW-1:0] bid;
    int              lat;
    int              beats;
    int              n;

    initial begin
        // Reset state
        repeat (3) tick();
        check_value("rst_awready", S_AXI_AWREADY, 0);
        check_value("rst_arready", S_AXI_ARREADY, 0);
        check_value("rst_wready",  S_AXI_WREADY, 0);
        check_value("rst_bvalid",  S_AXI_BVALID, 0);
        check_value("rst_rvalid",  S_AXI_RVALID, 0);
        check_value("rst_rlast",   S_AXI_RLAST, 0);
        check_value("rst_resp",    {S_AXI_BRESP, S_AXI_RRESP}, 0);
        check_value("rst_mem_en",  {mem_we, mem_re}, 0);
        ARESET = 1'b0;
        tick();

        // Basic 4-beat INCR write then read back
        wlog_addr.delete(); wlog_data.delete();
        do_write(c_TGT + 32'h10, 3, 2'b01, 32'hA0, 3, 2'd2, 3'd2, bresp, bid);
        check_value("wr1_bresp", bresp, 2'b00);
        check_value("wr1_bid", bid, 2'd2);
        check_value("wr1_nbeats", wlog_addr.size(), 4);
        for (int i = 0; i < 4 && i < wlog_addr.size(); i++) begin
            check_value("wr1_addr", wlog_addr[i], 4 + i);
            check_value("wr1_data", wlog_data[i], 32'hA0 + 32'(i));
        end
        do_read(c_TGT + 32'h10, 3, 2'b01, 2'd1, 1'b0, lat);
        check_value("rd1_latency", lat, 2);
        check_value("rd1_nbeats", rd_data.size(), 4);
        for (int i = 0; i < 4 && i < rd_data.size(); i++) begin
            check_value("rd1_data", rd_data[i], 32'hA0 + 32'(i));
            check_value("rd1_last", rd_last[i], (i == 3));
            check_value("rd1_resp", rd_resp[i], 2'b00);
            check_value("rd1_id", rd_id[i], 2'd1);
            check_value("rd1_b2b", rd_cyc[i] - rd_cyc[0], i);
        end

        // Simultaneous AW/AR: grants alternate write, read, write
        S_AXI_ARADDR = c_TGT + 32'h10; S_AXI_ARLEN = 8'd0; S_AXI_ARSIZE = 3'd2;
        S_AXI_ARBURST = 2'b01; S_AXI_ARID = 2'd3; S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR = c_TGT + 32'h40; S_AXI_AWLEN = 8'd0; S_AXI_AWSIZE = 3'd2;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        #1;
        check_value("arb1_awready", S_AXI_AWREADY, 1);
        check_value("arb1_arready", S_AXI_ARREADY, 0);
        do_write(c_TGT + 32'h40, 0, 2'b01, 32'h55, 0, 2'd0, 3'd2, bresp, bid);
        check_value("arb1_bresp", bresp, 2'b00);
        S_AXI_AWADDR = c_TGT + 32'h44; S_AXI_AWVALID = 1'b1;
        #1;
        check_value("arb2_awready", S_AXI_AWREADY, 0);
        check_value("arb2_arready", S_AXI_ARREADY, 1);
        do_read(c_TGT + 32'h10, 0, 2'b01, 2'd3, 1'b0, lat);
        check_value("arb2_rdata", (rd_data.size() > 0) ? rd_data[0] : 32'hDEAD, 32'hA0);
        S_AXI_ARADDR = c_TGT + 32'h10; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1'b1;
        #1;
        check_value("arb3_awready", S_AXI_AWREADY, 1);
        check_value("arb3_arready", S_AXI_ARREADY, 0);
        do_write(c_TGT + 32'h44, 0, 2'b01, 32'h66, 0, 2'd0, 3'd2, bresp, bid);
        S_AXI_ARVALID = 1'b0;
        check_value("arb3_bresp", bresp, 2'b00);

        // 8-beat read with RREADY toggling
        do_write(c_TGT + 32'h100, 7, 2'b01, 32'hB0, 7, 2'd1, 3'd2, bresp, bid);
        do_read(c_TGT + 32'h100, 7, 2'b01, 2'd0, 1'b1, lat);
        check_value("rd8_nbeats", rd_data.size(), 8);
        for (int i = 0; i < 8 && i < rd_data.size(); i++) begin
            check_value("rd8_data", rd_data[i], 32'hB0 + 32'(i));
            check_value("rd8_last", rd_last[i], (i == 7));
        end
        check_value("max_outstanding_le2", max_out <= 2, 1);

        // Window wrap and out-of-range addresses
        wlog_addr.delete(); wlog_data.delete();
        do_write(c_TGT + 32'd4092, 1, 2'b01, 32'hC0, 1, 2'd0, 3'd2, bresp, bid);
        check_value("wrap_bresp", bresp, 2'b00);
        check_value("wrap_nbeats", wlog_addr.size(), 2);
        if (wlog_addr.size() == 2) begin
            check_value("wrap_addr0", wlog_addr[0], 1023);
            check_value("wrap_addr1", wlog_addr[1], 0);
            check_value("wrap_data1", wlog_data[1], 32'hC1);
        end
        wlog_addr.delete(); wlog_data.delete();
        do_write(c_TGT + 32'd4096, 0, 2'b01, 32'hD0, 0, 2'd0, 3'd2, bresp, bid);
        check_value("oor_bresp", bresp, 2'b10);
        check_value("oor_no_we", wlog_addr.size(), 0);
        do_write(c_TGT - 32'd4, 0, 2'b01, 32'hD1, 0, 2'd0, 3'd2, bresp, bid);
        check_value("below_base_bresp", bresp, 2'b10);
        do_write(c_TGT + 32'h20, 0, 2'b01, 32'hD2, 0, 2'd0, 3'd1, bresp, bid);
        check_value("bad_size_bresp", bresp, 2'b10);
        check_value("bad_size_no_we", wlog_addr.size(), 0);

        // WLAST protocol errors
        do_write(c_TGT + 32'h20, 2, 2'b01, 32'hE0, 1, 2'd0, 3'd2, bresp, bid);
        check_value("early_wlast_bresp", bresp, 2'b10);
        do_write(c_TGT + 32'h20, 1, 2'b01, 32'hE8, 9, 2'd0, 3'd2, bresp, bid);
        check_value("missing_wlast_bresp", bresp, 2'b10);

        // FIXED burst
        wlog_addr.delete(); wlog_data.delete();
        do_write(c_TGT + 32'h20, 3, 2'b00, 32'hF0, 3, 2'd0, 3'd2, bresp, bid);
        check_value("fixed_bresp", bresp, 2'b00);
        check_value("fixed_nbeats", wlog_addr.size(), 4);
        for (int i = 0; i < 4 && i < wlog_addr.size(); i++) begin
            check_value("fixed_addr", wlog_addr[i], 8);
        end
        do_read(c_TGT + 32'h20, 0, 2'b01, 2'd0, 1'b0, lat);
        check_value("fixed_readback", (rd_data.size() > 0) ? rd_data[0] : 32'hDEAD, 32'hF3);

        // Reset during the third beat of an 8-beat read
        S_AXI_ARADDR = c_TGT + 32'h100; S_AXI_ARLEN = 8'd7; S_AXI_ARSIZE = 3'd2;
        S_AXI_ARBURST = 2'b01; S_AXI_ARID = 2'd0; S_AXI_ARVALID = 1'b1;
        #1;
        n = 0;
        while (!S_AXI_ARREADY && n < 32) begin tick(); #1; n++; end
        tick();
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        beats = 0; n = 0;
        while (n < 32) begin
            #1;
            if (S_AXI_RVALID) beats++;
            if (beats == 3) break;
            tick();
            n++;
        end
        check_value("midrst_reached_beat3", beats, 3);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0; S_AXI_RREADY = 1'b0;
        check_value("midrst_rvalid", S_AXI_RVALID, 0);
        check_value("midrst_wready", S_AXI_WREADY, 0);
        check_value("midrst_bvalid", S_AXI_BVALID, 0);
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = c_TGT;
        #1;
        check_value("midrst_awready_idle", S_AXI_AWREADY, 1);
        S_AXI_AWVALID = 1'b0;
        do_read(c_TGT + 32'h10, 0, 2'b01, 2'd2, 1'b0, lat);
        check_value("post_rst_latency", lat, 2);
        check_value("post_rst_data", (rd_data.size() > 0) ? rd_data[0] : 32'hDEAD, 32'hA0);
        check_value("post_rst_last", (rd_last.size() > 0) ? rd_last[0] : 1'b0, 1);

        check_value("we_re_exclusive", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/axi_slave_interface.md
Name: axi_slave_interface

Overview:
AXI4 slave (responder) that terminates the bursts issued by the team's AXI master interface. It converts them into a simple single-port, word-addressed memory interface with synchronous 1-cycle read latency, for use with on-chip BRAM/CoRAM models and slave-side test harnesses.
- Single outstanding transaction: one write or one read burst at a time.
- INCR/FIXED bursts, full-width beats only.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, AXI address width
C_S_AXI_DATA_WIDTH, 32, data width (8..1024, power of 2)
C_S_AXI_THREAD_ID_WIDTH, 1, ID width
C_S_AXI_TARGET, 'h00000000, byte base address of the window
C_MEM_ADDR_WIDTH, 10, word address width; window = 2^C_MEM_ADDR_WIDTH words

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESET  in  1  synchronous reset, active-high
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address
S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1
S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA/DATA/8/1/1  write data
S_AXI_WREADY  out  1
S_AXI_BID/BRESP/BVALID  out  ID/2/1; S_AXI_BREADY  in  1  write response
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address
S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1
S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID/DATA/2/1/1; S_AXI_RREADY  in  1
mem_addr  out  C_MEM_ADDR_WIDTH  word address
mem_we  out  1; mem_wdata  out  DATA; mem_wstrb  out  DATA/8
mem_re  out  1; mem_rdata  in  DATA  valid exactly 1 cycle after mem_re

Behaviour:
- Reset: all state → IDLE. All READY/VALID outputs, mem_we, mem_re = 0. BRESP/RRESP = 0, RLAST = 0, read buffer empty, last-grant = read (so write wins first tie). Reset mid-burst abandons the burst with no response.
- FSM IDLE → WDATA → WRESP → IDLE; IDLE → RDATA → IDLE.
- IDLE: AWREADY = 1 when AWVALID and (not ARVALID, or last grant was read); ARREADY symmetrically. Exactly one address handshake per cycle. On handshake, latch ID, len = AxLEN+1, burst type, word addr = (AxADDR − C_S_AXI_TARGET) >> log2(DATA/8).
- Range check: if (AxADDR − C_S_AXI_TARGET) ≥ 2^C_MEM_ADDR_WIDTH·DATA/8 (unsigned, includes below-base wrap), or AxSIZE ≠ log2(DATA/8), the burst is flagged err.
- Addressing: INCR: +1 word per beat, wrapping modulo 2^C_MEM_ADDR_WIDTH. FIXED: address held. WRAP (2'b10) treated as INCR.
- WDATA: WREADY = 1.
  - Each W handshake → same-cycle mem_we = ~err, mem_wdata/mem_wstrb = W bus.
  - Beat counter, not WLAST, ends the burst.
  - WLAST on a non-final beat, or missing on the final beat → sets err.
  - After the final beat → WRESP.
- WRESP: BVALID = 1, BID = latched ID, BRESP = err ? 2'b10 (SLVERR) : 2'b00. Held until BREADY, then IDLE. No new AW is accepted until then.
- RDATA: 2-entry output FIFO plus 1 in-flight read.
  - mem_re asserted when beats remain and (FIFO occupancy + in-flight) < 2, counting a same-cycle pop.
  - mem_rdata is pushed the next cycle; err bursts push zero data and still count beats.
  - RVALID = FIFO non-empty. RDATA = FIFO head, RID = latched ID, RRESP = err ? SLVERR : OKAY on every beat, RLAST on the last beat.
  - Back-to-back RVALID with RREADY held high, after a 2-cycle initial latency from the AR handshake.
  - RVALID/RDATA stable while RREADY = 0.
  - IDLE after the RLAST handshake.
- mem_we and mem_re are never asserted together.

Test Plan:
- AW addr=TARGET+0x10, AWLEN=3, 4 beats 0xA0..0xA3, strobe 0xF → mem_we at word 4..7 with matching data; BRESP=00, BID echoed. Then AR same addr, ARLEN=3, RREADY=1 → RDATA 0xA0..0xA3 on consecutive cycles, RLAST on beat 4, first RVALID 2 cycles after AR handshake.
- AWVALID and ARVALID asserted together from reset → write granted first, read next; repeat → order alternates.
- Read ARLEN=7 with RREADY toggled 1/0 every cycle → all 8 beats delivered in order, no duplicate or lost data, RVALID/RDATA stable while stalled, mem_re never exceeds 2 outstanding.
- AWADDR=TARGET+4·1023, AWLEN=1 (C_MEM_ADDR_WIDTH=10) → writes to words 1023 then 0. AWADDR=TARGET+4096 → no mem_we, BRESP=10.
- Write AWLEN=2 with WLAST on beat 2 → all 3 beats accepted, BRESP=10. FIXED burst AWLEN=3 → all mem_we at the same word.
- ARESET pulsed during the 3rd beat of an 8-beat read → next cycle RVALID=0, ARREADY/AWREADY reflect IDLE; a subsequent single-beat read returns correct data.
